// File: rtl/rmt_pkg.sv
// rmt_pkg: shared types and constants for the remote command controller
package rmt_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} cmd_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam int CLKS_PER_BIT_DEF = 434;
endpackage

// File: rtl/rmt_uart.sv
// rmt_uart: independent 8N1 transmitter and receiver sharing one bit period
module rmt_uart
  import rmt_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       TX,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic       rdy,
  output logic [7:0] rx_data
);
  localparam logic [11:0] LAST = 12'(CLKS_PER_BIT - 1);
  localparam logic [11:0] HALF = 12'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0] NBITS = 4'(UART_DATA_BITS);

  logic [11:0] tx_cnt;
  logic [3:0] tx_bits;
  logic [8:0] tx_shift;
  logic tx_busy;
  logic tx_tick;
  logic rx_ff1, rx_ff2, rx_ff3;
  logic rx_busy, rx_start;
  logic [11:0] rx_cnt;
  logic [3:0] rx_bits;
  logic [7:0] rx_shift;

  // done is combinational so the next frame can load on the same edge, leaving no gap
  assign tx_tick = tx_busy && tx_cnt == LAST;
  assign tx_done = tx_tick && tx_bits == NBITS + 4'd1;

  // transmitter: start bit driven on load, then data LSB first, then stop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      TX <= 1'b1;
      tx_busy <= 1'b0;
      tx_cnt <= '0;
      tx_bits <= '0;
      tx_shift <= '0;
    end else if (trmt) begin
      TX <= 1'b0;
      tx_busy <= 1'b1;
      tx_cnt <= '0;
      tx_bits <= '0;
      tx_shift <= {1'b1, tx_data};
    end else if (tx_done) begin
      TX <= 1'b1;
      tx_busy <= 1'b0;
      tx_cnt <= '0;
    end else if (tx_tick) begin
      TX <= tx_shift[0];
      tx_shift <= {1'b0, tx_shift[8:1]};
      tx_bits <= tx_bits + 4'd1;
      tx_cnt <= '0;
    end else if (tx_busy) begin
      tx_cnt <= tx_cnt + 12'd1;
    end

  // receiver: falling edge arms, mid-start recheck rejects glitches, mid-bit sampling
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_ff1 <= 1'b1;
      rx_ff2 <= 1'b1;
      rx_ff3 <= 1'b1;
      rx_busy <= 1'b0;
      rx_start <= 1'b0;
      rx_cnt <= '0;
      rx_bits <= '0;
      rx_shift <= '0;
      rx_data <= '0;
      rdy <= 1'b0;
    end else begin
      rx_ff1 <= RX;
      rx_ff2 <= rx_ff1;
      rx_ff3 <= rx_ff2;
      if (clr_rdy) rdy <= 1'b0;
      if (!rx_busy) begin
        rx_cnt <= '0;
        if (rx_ff3 && !rx_ff2) begin
          rx_busy <= 1'b1;
          rx_start <= 1'b1;
        end
      end else if (rx_start && rx_cnt == HALF) begin
        rx_cnt <= '0;
        rx_bits <= '0;
        rx_start <= 1'b0;
        rx_busy <= !rx_ff2;
        if (!rx_ff2) rdy <= 1'b0;
      end else if (!rx_start && rx_cnt == LAST) begin
        rx_cnt <= '0;
        if (rx_bits < NBITS) begin
          rx_shift <= {rx_ff2, rx_shift[7:1]};
          rx_bits <= rx_bits + 4'd1;
        end else begin
          rx_busy <= 1'b0;
          if (rx_ff2) begin
            rx_data <= rx_shift;
            rdy <= 1'b1;
          end
        end
      end else begin
        rx_cnt <= rx_cnt + 12'd1;
      end
    end
endmodule

// File: rtl/remote_comm_ctrl.sv
// remote_comm_ctrl: sends a 16-bit command as two UART bytes and receives a 1-byte reply
// Optional RMT_RESP_AUTOCLR_EN: an accepted command also clears resp_rdy.
module remote_comm_ctrl
  import rmt_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp
);
  cmd_state_t state;
  logic [15:0] hold;
  logic accept, trmt, tx_done, clr_rdy;
  logic [7:0] tx_data;

  // high byte comes straight from cmd so the start bit leaves one clock after snd_cmd
  assign accept = state == IDLE && snd_cmd;
  assign trmt = accept || (state == HIGH && tx_done);
  assign tx_data = state == IDLE ? cmd[15:8] : hold[7:0];
`ifdef RMT_RESP_AUTOCLR_EN
  assign clr_rdy = accept;
`else
  assign clr_rdy = 1'b0;
`endif

  // command sequencer: IDLE -> HIGH byte -> LOW byte -> IDLE with cmd_snt
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      hold <= '0;
      cmd_snt <= 1'b0;
    end else begin
      case (state)
        IDLE: if (snd_cmd) begin
          hold <= cmd;
          cmd_snt <= 1'b0;
          state <= HIGH;
        end
        HIGH: if (tx_done) state <= LOW;
        LOW: if (tx_done) begin
          cmd_snt <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end

  rmt_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk(clk),
    .rst_n(rst_n),
    .trmt(trmt),
    .tx_data(tx_data),
    .tx_done(tx_done),
    .TX(TX),
    .RX(RX),
    .clr_rdy(clr_rdy),
    .rdy(resp_rdy),
    .rx_data(resp)
  );
endmodule

// File: tb/tb_remote_comm_ctrl.sv
// tb_remote_comm_ctrl: directed checks of command send, response receive and reset
module tb_remote_comm_ctrl;
  localparam int CPB = 434;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_drv = 1'b1;
  logic loop = 1'b0;
  logic tx;
  logic rx_in;
  logic [15:0] cmd = '0;
  logic snd_cmd = 1'b0;
  logic cmd_snt, resp_rdy;
  logic [7:0] resp;
  int checks = 0;
  int failures = 0;
  int rdy_rises = 0;
  logic rdy_q = 1'b0;

  always #5 clk = ~clk;
  assign rx_in = loop ? tx : rx_drv;

  remote_comm_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .RX(rx_in), .TX(tx), .cmd(cmd),
    .snd_cmd(snd_cmd), .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp)
  );

  // counts rising edges of resp_rdy seen at negedges
  always @(negedge clk) begin
    if (resp_rdy && !rdy_q) rdy_rises++;
    rdy_q = resp_rdy;
  end

  task automatic run_send(input logic [15:0] c, input bit inject, output logic [19:0] fr,
                          output int snt_at, output logic tx1, output logic snt1);
    @(negedge clk);
    cmd = c;
    snd_cmd = 1'b1;
    snt_at = -1;
    fr = '0;
    tx1 = 1'b1;
    snt1 = 1'b1;
    for (int n = 1; n <= 9000; n++) begin
      @(negedge clk);
      if (n == 1) begin
        snd_cmd = 1'b0;
        tx1 = tx;
        snt1 = cmd_snt;
      end
      if (inject && n == 1000) begin
        cmd = 16'hFFFF;
        snd_cmd = 1'b1;
      end
      if (inject && n == 1001) snd_cmd = 1'b0;
      if (n <= 20 * CPB && (n - 1) % CPB == CPB / 2) fr[(n - 1) / CPB] = tx;
      if (snt_at < 0 && cmd_snt) snt_at = n;
    end
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks += 4;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    if (cmd_snt !== 1'b0) begin failures++; $display("FAIL reset_cmd_snt got=%b exp=0", cmd_snt); end
    if (resp_rdy !== 1'b0) begin failures++; $display("FAIL reset_resp_rdy got=%b exp=0", resp_rdy); end
    if (resp !== 8'h00) begin failures++; $display("FAIL reset_resp got=%h exp=00", resp); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_send;
    logic [19:0] fr;
    int snt_at;
    logic tx1, snt1;
    run_send(16'h2A5C, 1'b0, fr, snt_at, tx1, snt1);
    checks += 3;
    if (tx1 !== 1'b0) begin failures++; $display("FAIL send_start_latency tx=%b exp=0", tx1); end
    if (fr !== {1'b1, 8'h5C, 1'b0, 1'b1, 8'h2A, 1'b0}) begin
      failures++; $display("FAIL send_frame got=%b exp=%b", fr, {1'b1, 8'h5C, 1'b0, 1'b1, 8'h2A, 1'b0});
    end
    if (snt_at !== 8681) begin failures++; $display("FAIL send_cmd_snt_cycle got=%0d exp=8681", snt_at); end
  endtask

  task automatic test_busy;
    logic [19:0] fr;
    int snt_at;
    logic tx1, snt1;
    run_send(16'h2A5C, 1'b1, fr, snt_at, tx1, snt1);
    checks += 3;
    if (snt1 !== 1'b0) begin failures++; $display("FAIL busy_cmd_snt_cleared got=%b exp=0", snt1); end
    if (fr !== {1'b1, 8'h5C, 1'b0, 1'b1, 8'h2A, 1'b0}) begin
      failures++; $display("FAIL busy_frame got=%b exp=%b", fr, {1'b1, 8'h5C, 1'b0, 1'b1, 8'h2A, 1'b0});
    end
    if (snt_at !== 8681) begin failures++; $display("FAIL busy_cmd_snt_cycle got=%0d exp=8681", snt_at); end
  endtask

  task automatic test_rx;
    drive_rx(8'hA5, 1'b1);
    repeat (10) @(negedge clk);
    checks += 2;
    if (resp !== 8'hA5) begin failures++; $display("FAIL rx_a5_resp got=%h exp=a5", resp); end
    if (resp_rdy !== 1'b1) begin failures++; $display("FAIL rx_a5_rdy got=%b exp=1", resp_rdy); end
    fork
      drive_rx(8'h3C, 1'b1);
      begin
        repeat (CPB + CPB / 2) @(negedge clk);
        checks++;
        if (resp_rdy !== 1'b0) begin failures++; $display("FAIL rx_start_clears_rdy got=%b exp=0", resp_rdy); end
      end
    join
    repeat (10) @(negedge clk);
    checks += 2;
    if (resp !== 8'h3C) begin failures++; $display("FAIL rx_3c_resp got=%h exp=3c", resp); end
    if (resp_rdy !== 1'b1) begin failures++; $display("FAIL rx_3c_rdy got=%b exp=1", resp_rdy); end
  endtask

  task automatic test_framing;
    drive_rx(8'h77, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    checks += 2;
    if (resp !== 8'h3C) begin failures++; $display("FAIL framing_resp got=%h exp=3c", resp); end
    if (resp_rdy !== 1'b0) begin failures++; $display("FAIL framing_rdy got=%b exp=0", resp_rdy); end
  endtask

  task automatic test_glitch;
    rx_drv = 1'b0;
    repeat (100) @(negedge clk);
    rx_drv = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    checks += 2;
    if (resp_rdy !== 1'b0) begin failures++; $display("FAIL glitch_rdy got=%b exp=0", resp_rdy); end
    if (resp !== 8'h3C) begin failures++; $display("FAIL glitch_resp got=%h exp=3c", resp); end
  endtask

  task automatic test_loopback;
    logic [19:0] fr;
    int snt_at;
    logic tx1, snt1;
    loop = 1'b1;
    rdy_rises = 0;
    run_send(16'h1234, 1'b0, fr, snt_at, tx1, snt1);
    checks += 3;
    if (rdy_rises !== 2) begin failures++; $display("FAIL loop_rdy_pulses got=%0d exp=2", rdy_rises); end
    if (resp !== 8'h34) begin failures++; $display("FAIL loop_resp got=%h exp=34", resp); end
    if (resp_rdy !== 1'b1) begin failures++; $display("FAIL loop_rdy got=%b exp=1", resp_rdy); end
  endtask

  task automatic test_autoclr;
    logic exp_rdy;
`ifdef RMT_RESP_AUTOCLR_EN
    exp_rdy = 1'b0;
`else
    exp_rdy = 1'b1;
`endif
    @(negedge clk);
    cmd = 16'h0102;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    checks++;
    if (resp_rdy !== exp_rdy) begin failures++; $display("FAIL autoclr_rdy got=%b exp=%b", resp_rdy, exp_rdy); end
  endtask

  task automatic test_reset_mid;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (tx !== 1'b1) begin failures++; $display("FAIL mid_reset_tx got=%b exp=1", tx); end
    if (cmd_snt !== 1'b0) begin failures++; $display("FAIL mid_reset_cmd_snt got=%b exp=0", cmd_snt); end
    if (resp_rdy !== 1'b0) begin failures++; $display("FAIL mid_reset_resp_rdy got=%b exp=0", resp_rdy); end
    if (resp !== 8'h00) begin failures++; $display("FAIL mid_reset_resp got=%h exp=00", resp); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_send;
    test_busy;
    test_rx;
    test_framing;
    test_glitch;
    test_loopback;
    test_autoclr;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/remote_comm_ctrl.md
Name: remote_comm_ctrl

Overview:
- Host-side remote controller for the Knight's Tour system.
- Accepts a 16-bit command word and serialises it as two UART bytes on TX, high byte first.
- Reports completion, then receives the single-byte response from the robot on RX.
- Sits in the bench/host domain and drives the robot's RX line; the robot's TX line feeds back into this block's RX.

Parameters:
- CLKS_PER_BIT, 434, clocks per UART bit period; legal range 16..4095.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- RX  input  1  UART serial in (response from robot); asynchronous.
- TX  output  1  UART serial out (command to robot); idles high.
- cmd  input  16  command word; sampled only on an accepted snd_cmd.
- snd_cmd  input  1  single-cycle request to send cmd.
- cmd_snt  output  1  high once both bytes are fully transmitted; held until the next accepted snd_cmd.
- resp_rdy  output  1  high when a response byte is valid in resp.
- resp  output  8  last received response byte.

Behaviour:
- UART format: 8N1, LSB first, one start bit (0), one stop bit (1), each bit CLKS_PER_BIT clocks.
- Reset values: TX=1, cmd_snt=0, resp_rdy=0, resp=8'h00, FSM=IDLE, shift/count registers=0.
- Command FSM states:
  - IDLE: snd_cmd=1 latches cmd into a 16-bit holding register, clears cmd_snt, starts the high-byte frame, and goes to HIGH.
  - HIGH: when the high-byte frame completes, the low byte starts on the very next clock and the FSM goes to LOW.
  - LOW: when the low-byte frame completes, cmd_snt sets and the FSM returns to IDLE.
- Latency: the start bit appears on TX one clock after snd_cmd. cmd_snt rises 20*CLKS_PER_BIT+1 clocks after snd_cmd; there is no gap between the two frames.
- snd_cmd while not IDLE is ignored; changes on cmd after acceptance are ignored.
- Receiver:
  - RX passes through a 2-flop synchroniser, with both flops preset to 1 on reset.
  - A falling edge starts reception. The start bit is re-checked at half a bit period; if it is high the receiver returns to idle (glitch rejection).
  - Data bits are sampled mid-bit, then the stop bit is sampled.
  - Valid stop (1): resp loads the byte and resp_rdy sets in the same clock.
  - Framing error (stop=0): the byte is discarded, and resp and resp_rdy are unchanged.
- resp_rdy clears on the start-bit detection of the next incoming frame (default behaviour).
- The receiver is fully independent of the transmitter; simultaneous TX and RX activity is legal.
- Reset mid-frame: TX returns high immediately and any partial received byte is dropped.

Optional Feature:
- RMT_RESP_AUTOCLR_EN:
  - When defined, an accepted snd_cmd also clears resp_rdy in the same clock, so resp_rdy always refers to the current command.
  - When undefined, resp_rdy clears only on the next RX start-bit detection.

Decomposition:
- Shared package rmt_pkg holds:
  - typedef enum of the command FSM states (IDLE, HIGH, LOW);
  - localparam UART_DATA_BITS=8;
  - the default CLKS_PER_BIT constant.
- One natural sub-module: rmt_uart, a combined 8N1 transmitter/receiver with trmt/tx_done and rdy/rx_data/clr_rdy.
- The top level holds only the command FSM and the holding register.

Test Plan:
- Reset: assert rst_n=0 mid-simulation -> TX=1, cmd_snt=0, resp_rdy=0, resp=0 within the same cycle.
- Send cmd=16'h2A5C with a 1-cycle snd_cmd:
  - TX carries frame 0x2A (bits 0,1,0,1,0,1,0,0 after the start bit), then 0x5C, each bit 434 clocks;
  - cmd_snt rises at cycle 8681 after snd_cmd.
- Busy rejection: second snd_cmd with cmd=16'hFFFF issued 1000 cycles into the first send -> TX stream still 0x2A,0x5C only.
- Response: drive an RX frame 0xA5 at 434 clocks/bit -> resp=8'hA5 and resp_rdy=1 after the stop-bit sample. A following frame 0x3C clears resp_rdy at its start bit, then sets it with resp=8'h3C.
- Glitch and framing:
  - 100-cycle low pulse on RX -> no resp_rdy;
  - frame 0x77 with stop bit 0 -> resp stays 8'h3C, resp_rdy unchanged.
- Loopback (TX wired to RX) with cmd=16'h1234 -> resp_rdy pulses twice, resp ends at 8'h34. With RMT_RESP_AUTOCLR_EN defined, a new snd_cmd drops resp_rdy next cycle.
